// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and width helpers for the 1RW SRAM request controller
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_READ,
        GRANT_WRITE
    } grant_e;

    // Never below 1 so that a 1-entry or 2-entry structure still gets a usable vector.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// rtl/sram_resp_fifo.sv - circular read-response FIFO with occupancy count
module sram_resp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int BITS  = 7776,
    parameter int DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 push,
    input  logic [BITS-1:0]                      push_data,
    input  logic                                 pop,
    output logic                                 head_valid,
    output logic [BITS-1:0]                      head_data,
    output logic [clog2_min1(DEPTH+1)-1:0]       count
);

    localparam int PW = clog2_min1(DEPTH);
    localparam int CW = clog2_min1(DEPTH + 1);

    logic [BITS-1:0] mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop     = pop && (count != '0);
    assign head_valid = (count != '0);
    // Gate the head so an empty FIFO never exposes stale or uninitialised storage.
    assign head_data  = head_valid ? mem[head] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= next_ptr(tail);
            end
            if (do_pop) begin
                head <= next_ptr(head);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_data;
        end
    end

endmodule

// File: rtl/sram_1rw_req_ctrl.sv
// rtl/sram_1rw_req_ctrl.sv - merges read/write request channels onto a 1RW SRAM port
module sram_1rw_req_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int BITS       = 7776,
    parameter int WORD_DEPTH = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int RESP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr,
    input  logic                  wr_req_valid,
    output logic                  wr_req_ready,
    input  logic [ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [BITS-1:0]       wr_req_data,
    input  logic [BITS-1:0]       wr_req_mask,
    output logic                  rd_resp_valid,
    input  logic                  rd_resp_ready,
    output logic [BITS-1:0]       rd_resp_data,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [BITS-1:0]       sram_wd,
    output logic [BITS-1:0]       sram_wmask,
    input  logic [BITS-1:0]       sram_rd,
    output logic                  busy
);

    localparam int CW = clog2_min1(RESP_DEPTH + 1);

    if ($clog2(WORD_DEPTH) != ADDR_WIDTH) begin : g_bad_addr_width
        $error("ADDR_WIDTH does not match WORD_DEPTH");
    end
    if (RESP_DEPTH < 2) begin : g_bad_resp_depth
        $error("RESP_DEPTH must be at least 2");
    end

    grant_e          grant;
    grant_e          last_grant;
    logic            inflight;
    logic [CW-1:0]   occ;
    logic [CW:0]     outstanding;
    logic            pop;
    logic            credit_ok;
    logic            rd_elig;
    logic            wr_elig;

    // The pop frees its slot in the same cycle, so a full FIFO can still accept a read.
    assign pop         = rd_resp_valid & rd_resp_ready;
    assign outstanding = {1'b0, occ} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign credit_ok   = (outstanding < (CW+1)'(RESP_DEPTH));
    assign rd_elig     = rd_req_valid & credit_ok;
    assign wr_elig     = wr_req_valid;
    assign busy        = inflight | (occ != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight   <= 1'b0;
            last_grant <= GRANT_READ;
        end else begin
            inflight <= (grant == GRANT_READ);
            if (grant != GRANT_NONE) begin
                last_grant <= grant;
            end
        end
    end

    // Reset gates the grant so the macro is never enabled while rst_n is low.
    always_comb begin
        grant = GRANT_NONE;
        if (rst_n) begin
            if (rd_elig && wr_elig) begin
                grant = (last_grant == GRANT_READ) ? GRANT_WRITE : GRANT_READ;
            end else if (rd_elig) begin
                grant = GRANT_READ;
            end else if (wr_elig) begin
                grant = GRANT_WRITE;
            end
        end
    end

    always_comb begin
        rd_req_ready = 1'b0;
        wr_req_ready = 1'b0;
        sram_ce      = 1'b0;
        sram_we      = 1'b0;
        sram_addr    = '0;
        sram_wd      = '0;
        sram_wmask   = '0;
        case (grant)
            GRANT_READ: begin
                rd_req_ready = 1'b1;
                sram_ce      = 1'b1;
                sram_addr    = rd_req_addr;
            end
            GRANT_WRITE: begin
                wr_req_ready = 1'b1;
                sram_ce      = 1'b1;
                sram_we      = 1'b1;
                sram_addr    = wr_req_addr;
                sram_wd      = wr_req_data;
                sram_wmask   = wr_req_mask;
            end
            default: ;
        endcase
    end

    sram_resp_fifo #(
        .BITS  (BITS),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight),
        .push_data  (sram_rd),
        .pop        (rd_resp_ready),
        .head_valid (rd_resp_valid),
        .head_data  (rd_resp_data),
        .count      (occ)
    );

endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// tb/tb_sram_1rw_req_ctrl.sv - self-checking bench for sram_1rw_req_ctrl
module tb_sram_1rw_req_ctrl;

    localparam int BITS       = 64;
    localparam int WORD_DEPTH = 16;
    localparam int ADDR_WIDTH = 4;
    localparam int RESP_DEPTH = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  rd_req_valid = 1'b0;
    logic                  rd_req_ready;
    logic [ADDR_WIDTH-1:0] rd_req_addr = '0;
    logic                  wr_req_valid = 1'b0;
    logic                  wr_req_ready;
    logic [ADDR_WIDTH-1:0] wr_req_addr = '0;
    logic [BITS-1:0]       wr_req_data = '0;
    logic [BITS-1:0]       wr_req_mask = '0;
    logic                  rd_resp_valid;
    logic                  rd_resp_ready = 1'b0;
    logic [BITS-1:0]       rd_resp_data;
    logic                  sram_ce;
    logic                  sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [BITS-1:0]       sram_wd;
    logic [BITS-1:0]       sram_wmask;
    logic [BITS-1:0]       sram_rd = '0;
    logic                  busy;

    always #5 clk = ~clk;

    sram_1rw_req_ctrl #(
        .BITS       (BITS),
        .WORD_DEPTH (WORD_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESP_DEPTH (RESP_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_req_addr   (wr_req_addr),
        .wr_req_data   (wr_req_data),
        .wr_req_mask   (wr_req_mask),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_ready (rd_resp_ready),
        .rd_resp_data  (rd_resp_data),
        .sram_ce       (sram_ce),
        .sram_we       (sram_we),
        .sram_addr     (sram_addr),
        .sram_wd       (sram_wd),
        .sram_wmask    (sram_wmask),
        .sram_rd       (sram_rd),
        .busy          (busy)
    );

    function automatic logic [BITS-1:0] rnd_word();
        logic [BITS-1:0] w;
        for (int i = 0; i < BITS; i += 32) w[i +: 32] = $urandom;
        return w;
    endfunction

    // Macro model: garbage on rd_out whenever the previous cycle was not a read.
    logic [BITS-1:0] mac_mem [WORD_DEPTH];
    always @(posedge clk) begin
        if (sram_ce && sram_we)
            mac_mem[sram_addr] <= (mac_mem[sram_addr] & ~sram_wmask) | (sram_wd & sram_wmask);
        if (sram_ce && !sram_we) sram_rd <= mac_mem[sram_addr];
        else                     sram_rd <= rnd_word();
    end

    // Reference: memory contents by accepted writes, and a queue of accepted reads.
    typedef struct {
        logic [BITS-1:0] data;
        int              due;
    } resp_t;

    logic [BITS-1:0] ref_mem [WORD_DEPTH];
    resp_t           q[$];
    bit              last_rd = 1'b1;
    int              cyc = 0;
    int              passed = 0;
    int              failed = 0;
    int              total = 0;
    int              rd_acc = 0;
    int              wr_acc = 0;
    int              base;

    task automatic chk(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        bit pop, rd_el, wr_el, g_rd, g_wr, exp_valid;
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_rd_ready", rd_req_ready, 0);
            chk("rst_wr_ready", wr_req_ready, 0);
            chk("rst_ce", sram_ce, 0);
            chk("rst_we", sram_we, 0);
            chk("rst_addr", sram_addr, 0);
            chk("rst_wd", sram_wd, 0);
            chk("rst_wmask", sram_wmask, 0);
            chk("rst_resp_valid", rd_resp_valid, 0);
            chk("rst_busy", busy, 0);
        end else begin
            exp_valid = (q.size() > 0) && (q[0].due <= cyc);
            pop   = exp_valid && rd_resp_ready;
            rd_el = rd_req_valid && ((q.size() - int'(pop)) < RESP_DEPTH);
            wr_el = wr_req_valid;
            g_wr  = wr_el && (!rd_el || last_rd);
            g_rd  = rd_el && !g_wr;
            chk("rd_req_ready", rd_req_ready, g_rd);
            chk("wr_req_ready", wr_req_ready, g_wr);
            chk("sram_ce", sram_ce, g_rd || g_wr);
            chk("sram_we", sram_we, g_wr);
            chk("sram_addr", sram_addr, g_rd ? rd_req_addr : (g_wr ? wr_req_addr : '0));
            chk("sram_wd", sram_wd, g_wr ? wr_req_data : '0);
            chk("sram_wmask", sram_wmask, g_wr ? wr_req_mask : '0);
            chk("rd_resp_valid", rd_resp_valid, exp_valid);
            if (exp_valid) chk("rd_resp_data", rd_resp_data, q[0].data);
            chk("busy", busy, q.size() > 0);
            if (pop) void'(q.pop_front());
            if (g_rd) begin
                q.push_back('{data: ref_mem[rd_req_addr], due: cyc + 2});
                last_rd = 1'b1;
                rd_acc++;
            end
            if (g_wr) begin
                ref_mem[wr_req_addr] = (ref_mem[wr_req_addr] & ~wr_req_mask) | (wr_req_data & wr_req_mask);
                last_rd = 1'b0;
                wr_acc++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle();
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;
    endtask

    task automatic wr(input int a, input logic [BITS-1:0] d, input logic [BITS-1:0] m);
        wr_req_valid = 1'b1; wr_req_addr = ADDR_WIDTH'(a); wr_req_data = d; wr_req_mask = m;
    endtask

    task automatic rd(input int a);
        rd_req_valid = 1'b1; rd_req_addr = ADDR_WIDTH'(a);
    endtask

    initial begin
        for (int i = 0; i < WORD_DEPTH; i++) begin
            mac_mem[i] = rnd_word();
            ref_mem[i] = mac_mem[i];
        end

        // Reset with requests pending: macro must stay disabled.
        wr(1, '1, '1); rd(2); rd_resp_ready = 1'b1;
        step(); step();

        // Tie from reset: W,R,W,R...
        @(posedge clk); #1; rst_n = 1'b1;
        base = rd_acc;
        for (int i = 0; i < 8; i++) step();
        chk("tie_reads", rd_acc - base, 4);
        chk("tie_writes", wr_acc, 4);

        // Write addr 5 then read it.
        idle(); step(); step();
        wr(5, '1, '1); step();
        idle(); rd(5); step();
        idle(); step(); step(); step();

        // Masked write: hold the response so its data can be checked explicitly.
        wr(9, '0, '1); step();
        wr(9, '1, BITS'(64'hFF)); step();
        idle(); rd(9); rd_resp_ready = 1'b0; step();
        idle(); step(); step();
        chk("masked_data", rd_resp_data, BITS'(64'hFF));
        rd_resp_ready = 1'b1; step(); step();

        // Read-then-write ordering on addr 3.
        wr(3, BITS'(64'hA), '1); step();
        idle(); rd(3); step();
        idle(); wr(3, BITS'(64'hB), '1); step();
        idle(); step(); step();
        rd(3); step();
        idle(); step(); step(); step();

        // Backpressure: only RESP_DEPTH reads accepted, writes still flow.
        rd_resp_ready = 1'b0;
        base = rd_acc;
        for (int i = 0; i < 4; i++) begin rd(i); step(); end
        chk("bp_accepts", rd_acc - base, 2);
        wr(7, rnd_word(), '1); step();
        idle(); rd(12); step();
        chk("bp_rd_stalled", rd_acc - base, 2);
        rd_resp_ready = 1'b1;
        base = rd_acc;
        for (int i = 0; i < 8; i++) begin rd(i); step(); end
        chk("bp_resume_rate", rd_acc - base, 8);
        idle(); step(); step(); step();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            rd_req_valid  = ($urandom_range(0, 3) != 0);
            rd_req_addr   = ADDR_WIDTH'($urandom);
            wr_req_valid  = ($urandom_range(0, 2) == 0);
            wr_req_addr   = ADDR_WIDTH'($urandom);
            wr_req_data   = rnd_word();
            wr_req_mask   = rnd_word();
            rd_resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        idle(); rd_resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Reset between a read grant and its capture.
        rd(4); step();
        rst_n = 1'b0;
        #1;
        chk("midrst_ce", sram_ce, 0);
        chk("midrst_rd_ready", rd_req_ready, 0);
        chk("midrst_resp_valid", rd_resp_valid, 0);
        chk("midrst_busy", busy, 0);
        q.delete();
        last_rd = 1'b1;
        step(); step();
        @(posedge clk); #1; rst_n = 1'b1;
        idle();
        for (int i = 0; i < 5; i++) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sram_1rw_req_ctrl.md
Name: sram_1rw_req_ctrl

Overview:
Request front-end that sits directly upstream of the sram_*_1rw macros, for example the 7776x1024 single-port array. It merges independent read and write valid/ready channels onto the single RW port and drives ce/we/addr/wd/w_mask. It captures the macro's 1-cycle read data into a small response FIFO with valid/ready backpressure, so callers never sample the raw rd_out, which is X when ce is low.

Parameters:
BITS, 7776, data and mask width; must equal the macro's BITS.
WORD_DEPTH, 1024, number of words in the macro.
ADDR_WIDTH, 10, address width; must equal clog2(WORD_DEPTH).
RESP_DEPTH, 2, response FIFO entries; minimum 2, which is required for 1 read per cycle.

Ports:
clk  in  1  clock, shared with the macro.
rst_n  in  1  asynchronous active-low reset.
rd_req_valid  in  1  read request valid.
rd_req_ready  out  1  read request accepted this cycle.
rd_req_addr  in  ADDR_WIDTH  read address.
wr_req_valid  in  1  write request valid.
wr_req_ready  out  1  write request accepted this cycle.
wr_req_addr  in  ADDR_WIDTH  write address.
wr_req_data  in  BITS  write data.
wr_req_mask  in  BITS  per-bit write enable (1 = write).
rd_resp_valid  out  1  response FIFO head valid.
rd_resp_ready  in  1  consumer pops the head.
rd_resp_data  out  BITS  response FIFO head data.
sram_ce  out  1  to macro ce_in.
sram_we  out  1  to macro we_in.
sram_addr  out  ADDR_WIDTH  to macro addr_in.
sram_wd  out  BITS  to macro wd_in.
sram_wmask  out  BITS  to macro w_mask_in.
sram_rd  in  BITS  from macro rd_out.
busy  out  1  read in flight or FIFO non-empty.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - All of the following read 0: rd_req_ready, wr_req_ready, rd_resp_valid, sram_ce, sram_we, sram_addr, sram_wd, sram_wmask, busy.
  - FIFO is empty, the in-flight flag is cleared, and last_grant = READ.
  - While rst_n is low, sram_ce is forced to 0 regardless of the request inputs.
- Read credit:
  - credit_ok = (occupancy + inflight - pop) < RESP_DEPTH.
  - pop = rd_resp_valid & rd_resp_ready, in the same cycle.
- Eligibility:
  - A read is eligible when rd_req_valid & credit_ok.
  - A write is eligible when wr_req_valid. Writes need no credit.
- Arbitration (combinational, one grant per cycle):
  - If only one request is eligible, it wins.
  - If both are eligible, the type opposite to last_grant wins.
  - last_grant updates only on a grant.
  - After reset, the first tie goes to WRITE.
- The ready signal is asserted only for the granted channel. Requests follow AXI-style rules: valid must not depend on ready.
- Macro drive (combinational from the grant, sampled by the macro on the same edge):
  - Read grant: ce=1, we=0, addr=rd_req_addr, wd=0, wmask=0.
  - Write grant: ce=1, we=1, addr=wr_req_addr, wd=wr_req_data, wmask=wr_req_mask.
  - No grant: ce=0, we=0, addr/wd/wmask=0. The outputs must never be X while out of reset.
- Read latency:
  - A read granted in cycle T sets inflight in T+1.
  - sram_rd is pushed into the FIFO at the end of T+1.
  - rd_resp_valid is asserted from T+2, with data = mem[addr] as of before T.
- sram_rd is ignored in every cycle not preceded by a read grant, including cycles after a write grant, because the macro returns old data or X.
- Ordering:
  - Responses return in request order.
  - A write granted before a read to the same address is visible to that read, because the port is serialised.
  - A read granted before a write returns the old data.
- FIFO:
  - Circular buffer with wrapping head/tail pointers and an occupancy counter of width clog2(RESP_DEPTH+1).
  - Push and pop in the same cycle are legal, including when full, since credit accounted for the pop.
  - Pop when empty is ignored.
  - Push when full is impossible by construction; the verification engineer asserts this.
- Backpressure: rd_resp_ready held low fills the FIFO, then rd_req_ready drops. Writes continue to be granted.
- Reset mid-operation: any in-flight read and all FIFO contents are discarded. No response is produced for them.
- busy = inflight | (occupancy != 0).

Decomposition:
- The package sram_ctrl_pkg holds the grant_e enum {GRANT_NONE, GRANT_READ, GRANT_WRITE} and a function that computes clog2-based widths.
- One sub-module, sram_resp_fifo: a parameterised BITS x RESP_DEPTH synchronous FIFO with async active-low reset, exposing count, push, and pop.

Test Plan:
- Write then read, single channel:
  - Stimulus: write addr 5, data all-ones, mask all-ones in cycle 0; read addr 5 in cycle 1.
  - Required response: sram_we=1 in cycle 0; rd_resp_valid in cycle 3 with data all-ones.
- Masked write:
  - Stimulus: preload addr 9 = 0; write data all-ones with mask = low 8 bits set; then read addr 9.
  - Required response: response data = 0xFF in the low bits, 0 elsewhere.
- Tie arbitration:
  - Stimulus: read and write both valid continuously from reset, rd_resp_ready=1.
  - Required response: grants alternate W,R,W,R; each channel gets one accept every 2 cycles.
- Backpressure:
  - Stimulus: rd_resp_ready=0; issue 4 back-to-back reads.
  - Required response: exactly 2 accepted, rd_req_ready=0 afterward, sram_ce=0 on further reads.
  - Then: raise ready. Required response: responses arrive in order and full throughput resumes with 1 read per cycle.
- Read-then-write ordering:
  - Stimulus: addr 3 holds 0xA; read addr 3 granted in cycle T, write 0xB to addr 3 in T+1.
  - Required response: the response is 0xA; a subsequent read returns 0xB.
- Reset mid-operation:
  - Stimulus: assert rst_n low between a read grant and its capture.
  - Required response: all outputs go to 0 immediately; no response appears after reset release; busy=0.
